npc_ctrl: RTL and testbench

Multi-cycle sequencing controller for the npc core. It owns the PC and instruction registers and fetches over a request/acknowledge memory port. It steps each instruction through fetch, execute, optional memory access and write-back, gating register-file writes and PC updates to one cycle per instruction. It halts permanently on ebreak, illegal instruction or memory timeout.

---
 rtl/npc_ctrl_pkg.sv | 29 ++
 rtl/npc_ctrl_if.sv | 31 +++
 rtl/npc_timeout_cnt.sv | 45 ++++
 rtl/npc_ctrl.sv | 154 +++++++++++++++
 tb/tb_npc_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/npc_ctrl_pkg.sv
// rtl/npc_ctrl_pkg.sv - shared types and constants for the npc sequencing controller
// Contents: controller state encoding, halt-cause codes, reset instruction/PC
// defaults and the timeout counter width helper.
package npc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_HALT  = 3'd5
    } state_e;

    localparam logic [1:0] HALT_NONE    = 2'd0;
    localparam logic [1:0] HALT_EBREAK  = 2'd1;
    localparam logic [1:0] HALT_ILLEGAL = 2'd2;
    localparam logic [1:0] HALT_TIMEOUT = 2'd3;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST         = 32'h00000013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h80000000;

    // Width that holds 0..limit; a disabled (zero) limit still needs one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/npc_ctrl_if.sv
// rtl/npc_ctrl_if.sv - instruction fetch and load/store request/ack port bundle
// master: controller side (drives requests and fetch address)
// slave : memory side (drives acks and fetched instruction)
interface npc_ctrl_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        lsu_req;
    logic        lsu_ack;

    modport master (
        output imem_req,
        output imem_addr,
        output lsu_req,
        input  imem_ack,
        input  imem_rdata,
        input  lsu_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        input  lsu_req,
        output imem_ack,
        output imem_rdata,
        output lsu_ack
    );

endinterface

// File: rtl/npc_timeout_cnt.sv
// rtl/npc_timeout_cnt.sv - saturating wait-cycle counter with expiry flag
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear_i   : restart counting from zero (wins over en_i)
//   en_i      : a wait cycle elapsed without acknowledge
//   expired_o : this wait cycle is the LIMIT-th one; never set when LIMIT is 0
module npc_timeout_cnt
    import npc_ctrl_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = cnt_width(LIMIT);
    localparam logic [W-1:0] MAX_CNT  = W'(LIMIT);
    // Value held during the final permitted wait cycle.
    localparam logic [W-1:0] LAST_CNT = W'(LIMIT - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != MAX_CNT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (LIMIT != 0) && en_i && !clear_i && (count_q == LAST_CNT);

endmodule

// File: rtl/npc_ctrl.sv
// rtl/npc_ctrl.sv - multi-cycle fetch/execute/memory/write-back sequencer for the npc core
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (master)    : imem_req/imem_addr/imem_ack/imem_rdata, lsu_req/lsu_ack
//   dec_*           : external decoder flags for the latched instruction
//   next_pc         : external ALU next-PC result
//   pc, inst        : architectural PC and instruction registers
//   reg_wen, commit : register-file write enable, one-cycle retire pulse
//   instret         : retired-instruction counter (wraps)
//   halted, halt_code : sticky stop flag and cause
module npc_ctrl
    import npc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    npc_ctrl_if.master    bus,
    input  logic          dec_is_ebreak,
    input  logic          dec_illegal,
    input  logic          dec_is_mem,
    input  logic          dec_rd_wen,
    input  logic [31:0]   next_pc,
    output logic [31:0]   pc,
    output logic [31:0]   inst,
    output logic          reg_wen,
    output logic          commit,
    output logic [31:0]   instret,
    output logic          halted,
    output logic [1:0]    halt_code
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] instret_q, instret_d;
    logic [1:0]  halt_code_q, halt_code_d;

    logic imem_req, lsu_req;
    logic cnt_clear, cnt_en, cnt_expired;

    // One counter serves both wait states; it is held clear in every other
    // state, so entering FETCH or MEM always starts from zero.
    npc_timeout_cnt #(
        .LIMIT(MEM_TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (cnt_clear),
        .en_i     (cnt_en),
        .expired_o(cnt_expired)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        instret_d   = instret_q;
        halt_code_d = halt_code_q;
        imem_req    = 1'b0;
        lsu_req     = 1'b0;
        reg_wen     = 1'b0;
        commit      = 1'b0;
        cnt_clear   = 1'b1;
        cnt_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req  = 1'b1;
                cnt_clear = 1'b0;
                cnt_en    = !bus.imem_ack;
                // An ack on the limit cycle is checked first, so it wins.
                if (bus.imem_ack) begin
                    inst_d  = bus.imem_rdata;
                    state_d = ST_EXEC;
                end else if (cnt_expired) begin
                    halt_code_d = HALT_TIMEOUT;
                    state_d     = ST_HALT;
                end
            end
            ST_EXEC: begin
                if (dec_is_ebreak) begin
                    // ebreak itself retires, then the core stops.
                    commit      = 1'b1;
                    instret_d   = instret_q + 32'd1;
                    halt_code_d = HALT_EBREAK;
                    state_d     = ST_HALT;
                end else if (dec_illegal) begin
                    halt_code_d = HALT_ILLEGAL;
                    state_d     = ST_HALT;
                end else if (dec_is_mem) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                lsu_req   = 1'b1;
                cnt_clear = 1'b0;
                cnt_en    = !bus.lsu_ack;
                if (bus.lsu_ack) begin
                    state_d = ST_WB;
                end else if (cnt_expired) begin
                    halt_code_d = HALT_TIMEOUT;
                    state_d     = ST_HALT;
                end
            end
            ST_WB: begin
                reg_wen   = dec_rd_wen;
                commit    = 1'b1;
                pc_d      = next_pc;
                instret_d = instret_q + 32'd1;
                state_d   = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            inst_q      <= NOP_INST;
            instret_q   <= 32'd0;
            halt_code_q <= HALT_NONE;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            instret_q   <= instret_d;
            halt_code_q <= halt_code_d;
        end
    end

    assign bus.imem_req  = imem_req;
    assign bus.imem_addr = pc_q;
    assign bus.lsu_req   = lsu_req;

    assign pc        = pc_q;
    assign inst      = inst_q;
    assign instret   = instret_q;
    assign halted    = (state_q == ST_HALT);
    assign halt_code = halt_code_q;

endmodule

// File: tb/tb_npc_ctrl.sv
// tb/tb_npc_ctrl.sv - self-checking bench for npc_ctrl
module tb_npc_ctrl;
    import npc_ctrl_pkg::*;

    localparam logic [31:0] PC0    = 32'h80000000;
    localparam logic [31:0] PC1    = 32'h80000004;
    localparam logic [31:0] PC2    = 32'h80000008;
    localparam logic [31:0] PC3    = 32'h8000000C;
    localparam logic [31:0] PC4    = 32'h80000010;
    localparam logic [31:0] ADDI5  = 32'h00500093;
    localparam logic [31:0] ADDI10 = 32'h00A00113;
    localparam logic [31:0] LW     = 32'h0000A183;
    localparam logic [31:0] EBRK   = 32'h00100073;
    localparam logic [31:0] JUNK   = 32'hDEADBEEF;
    localparam logic B1 = 1'b1;
    localparam logic B0 = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_is_ebreak, dec_illegal, dec_is_mem, dec_rd_wen;
    logic [31:0] next_pc;
    logic [31:0] pc, inst, instret;
    logic        reg_wen, commit, halted;
    logic [1:0]  halt_code;

    always #5 clk = ~clk;

    npc_ctrl_if bus ();

    npc_ctrl #(
        .RESET_PC   (32'h80000000),
        .MEM_TIMEOUT(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .dec_is_ebreak(dec_is_ebreak),
        .dec_illegal  (dec_illegal),
        .dec_is_mem   (dec_is_mem),
        .dec_rd_wen   (dec_rd_wen),
        .next_pc      (next_pc),
        .pc           (pc),
        .inst         (inst),
        .reg_wen      (reg_wen),
        .commit       (commit),
        .instret      (instret),
        .halted       (halted),
        .halt_code    (halt_code)
    );

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ebrk, ill, mem, rdw;
        logic [31:0] npc;
        logic        lack;
        logic        ireq, lreq, rwen, cmt;
        logic [31:0] epc, einst, eret;
        logic        ehalt;
        logic [1:0]  ecode;
    } vec_t;

    vec_t vecs[21];
    vec_t idle_v;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.imem_ack   = v.ack;
        bus.imem_rdata = v.rdata;
        dec_is_ebreak  = v.ebrk;
        dec_illegal    = v.ill;
        dec_is_mem     = v.mem;
        dec_rd_wen     = v.rdw;
        next_pc        = v.npc;
        bus.lsu_ack    = v.lack;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " imem_req"},  32'(bus.imem_req), 32'(v.ireq));
        check({tag, " imem_addr"}, bus.imem_addr,     v.epc);
        check({tag, " lsu_req"},   32'(bus.lsu_req),  32'(v.lreq));
        check({tag, " reg_wen"},   32'(reg_wen),      32'(v.rwen));
        check({tag, " commit"},    32'(commit),       32'(v.cmt));
        check({tag, " pc"},        pc,                v.epc);
        check({tag, " inst"},      inst,              v.einst);
        check({tag, " instret"},   instret,           v.eret);
        check({tag, " halted"},    32'(halted),       32'(v.ehalt));
        check({tag, " halt_code"}, 32'(halt_code),    32'(v.ecode));
    endtask

    // Leaves the bench at a negedge with the DUT in IDLE and rst released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(idle_v);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        idle_v = '{B0, 32'd0, B0, B0, B0, B0, 32'd0, B0,
                   B0, B0, B0, B0, PC0, NOP_INST, 32'd0, B0, 2'd0};
        rst = 1'b1;
        drive(idle_v);

        //            ack rdata   eb  il  mem rdw npc  lack | ireq lreq rwen cmt  pc   inst      instret   halt code
        vecs[0]  = '{B1, ADDI5,  B0, B0, B0, B0, PC1, B0,   B0, B0, B0, B0, PC0, NOP_INST, 32'd0, B0, 2'd0}; // IDLE
        vecs[1]  = '{B1, ADDI5,  B0, B0, B0, B0, PC1, B0,   B1, B0, B0, B0, PC0, NOP_INST, 32'd0, B0, 2'd0}; // FETCH ack
        vecs[2]  = '{B1, ADDI5,  B0, B0, B0, B1, PC1, B0,   B0, B0, B0, B0, PC0, ADDI5,    32'd0, B0, 2'd0}; // EXEC
        vecs[3]  = '{B1, ADDI5,  B0, B0, B0, B1, PC1, B0,   B0, B0, B1, B1, PC0, ADDI5,    32'd0, B0, 2'd0}; // WB
        vecs[4]  = '{B0, JUNK,   B0, B0, B0, B0, PC2, B0,   B1, B0, B0, B0, PC1, ADDI5,    32'd1, B0, 2'd0}; // FETCH wait 1
        vecs[5]  = '{B0, JUNK,   B0, B0, B0, B0, PC2, B0,   B1, B0, B0, B0, PC1, ADDI5,    32'd1, B0, 2'd0}; // wait 2
        vecs[6]  = '{B0, JUNK,   B0, B0, B0, B0, PC2, B0,   B1, B0, B0, B0, PC1, ADDI5,    32'd1, B0, 2'd0}; // wait 3
        vecs[7]  = '{B0, JUNK,   B0, B0, B0, B0, PC2, B0,   B1, B0, B0, B0, PC1, ADDI5,    32'd1, B0, 2'd0}; // wait 4
        vecs[8]  = '{B1, ADDI10, B0, B0, B0, B0, PC2, B0,   B1, B0, B0, B0, PC1, ADDI5,    32'd1, B0, 2'd0}; // ack
        vecs[9]  = '{B1, JUNK,   B0, B0, B0, B0, PC2, B0,   B0, B0, B0, B0, PC1, ADDI10,   32'd1, B0, 2'd0}; // EXEC, stray ack
        vecs[10] = '{B0, JUNK,   B0, B0, B0, B0, PC2, B0,   B0, B0, B0, B1, PC1, ADDI10,   32'd1, B0, 2'd0}; // WB no rd
        vecs[11] = '{B1, LW,     B0, B0, B0, B0, PC3, B0,   B1, B0, B0, B0, PC2, ADDI10,   32'd2, B0, 2'd0}; // FETCH
        vecs[12] = '{B0, JUNK,   B0, B0, B1, B1, PC3, B0,   B0, B0, B0, B0, PC2, LW,       32'd2, B0, 2'd0}; // EXEC mem
        vecs[13] = '{B0, JUNK,   B0, B0, B1, B1, PC3, B0,   B0, B1, B0, B0, PC2, LW,       32'd2, B0, 2'd0}; // MEM wait
        vecs[14] = '{B0, JUNK,   B0, B0, B1, B1, PC3, B0,   B0, B1, B0, B0, PC2, LW,       32'd2, B0, 2'd0}; // MEM wait
        vecs[15] = '{B0, JUNK,   B0, B0, B1, B1, PC3, B1,   B0, B1, B0, B0, PC2, LW,       32'd2, B0, 2'd0}; // MEM ack
        vecs[16] = '{B0, JUNK,   B0, B0, B1, B1, PC3, B0,   B0, B0, B1, B1, PC2, LW,       32'd2, B0, 2'd0}; // WB
        vecs[17] = '{B1, EBRK,   B0, B0, B0, B0, PC4, B0,   B1, B0, B0, B0, PC3, LW,       32'd3, B0, 2'd0}; // FETCH
        vecs[18] = '{B0, JUNK,   B1, B0, B0, B0, PC4, B0,   B0, B0, B0, B1, PC3, EBRK,     32'd3, B0, 2'd0}; // EXEC ebreak
        vecs[19] = '{B1, JUNK,   B1, B0, B1, B1, PC4, B1,   B0, B0, B0, B0, PC3, EBRK,     32'd4, B1, 2'd1}; // HALT
        vecs[20] = '{B1, ADDI5,  B1, B0, B0, B1, PC4, B1,   B0, B0, B0, B0, PC3, EBRK,     32'd4, B1, 2'd1}; // HALT

        // Reset state, sampled while rst is still asserted.
        @(negedge clk);
        @(negedge clk);
        #1;
        check_all("reset", idle_v);

        do_reset();
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i]);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i]);
            @(negedge clk);
        end

        // Fetch never acknowledged: 8 wait cycles then timeout halt.
        do_reset();
        drive(idle_v);
        n = 0;
        for (int c = 0; c < 40 && !halted; c++) begin
            #1;
            if (bus.imem_req) n++;
            @(negedge clk);
        end
        #1;
        check("timeout halted",    32'(halted),       32'd1);
        check("timeout code",      32'(halt_code),    32'(HALT_TIMEOUT));
        check("timeout req cycles", 32'(n),           32'd8);
        check("timeout req low",   32'(bus.imem_req), 32'd0);
        check("timeout pc",        pc,                PC0);
        check("timeout instret",   instret,           32'd0);

        // Ack on the 8th wait cycle wins; then an illegal instruction halts.
        do_reset();
        drive(idle_v);
        @(negedge clk);
        for (int k = 1; k < 8; k++) begin
            #1;
            check($sformatf("late ack req c%0d", k), 32'(bus.imem_req), 32'd1);
            @(negedge clk);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hFFFFFFFF;
        #1;
        check("limit ack not halted", 32'(halted), 32'd0);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        dec_illegal  = 1'b1;
        #1;
        check("limit ack exec halted", 32'(halted), 32'd0);
        check("limit ack inst",        inst,        32'hFFFFFFFF);
        check("illegal commit",        32'(commit), 32'd0);
        @(negedge clk);
        #1;
        check("illegal halted",  32'(halted),    32'd1);
        check("illegal code",    32'(halt_code), 32'(HALT_ILLEGAL));
        check("illegal instret", instret,        32'd0);
        check("illegal pc",      pc,             PC0);

        // Reset while a load is waiting for lsu_ack.
        do_reset();
        drive(idle_v);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = ADDI5;
        dec_rd_wen     = 1'b1;
        next_pc        = PC1;
        repeat (4) @(negedge clk);
        #1;
        check("rstmem instret pre", instret, 32'd1);
        bus.imem_rdata = LW;
        dec_is_mem     = 1'b1;
        next_pc        = PC2;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        @(negedge clk);
        #1;
        check("rstmem lsu_req", 32'(bus.lsu_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rstmem lsu_req drop", 32'(bus.lsu_req),  32'd0);
        check("rstmem imem_req",     32'(bus.imem_req), 32'd0);
        check("rstmem pc",           pc,                PC0);
        check("rstmem instret",      instret,           32'd0);
        check("rstmem inst",         inst,              NOP_INST);
        rst         = 1'b0;
        bus.lsu_ack = 1'b1;
        #1;
        check("late lsu_ack reg_wen", 32'(reg_wen), 32'd0);
        check("late lsu_ack commit",  32'(commit),  32'd0);
        @(negedge clk);
        bus.lsu_ack = 1'b0;
        #1;
        check("after reset fetch req", 32'(bus.imem_req), 32'd1);
        check("after reset lsu_req",   32'(bus.lsu_req),  32'd0);
        check("after reset pc",        pc,                PC0);
        check("after reset instret",   instret,           32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
